// File: rtl/run_limit_tx.sv
// rtl/run_limit_tx.sv - serializer that bit-stuffs to bound runs of identical bits
module run_limit_tx #(
  parameter int DATA_W    = 8,
  parameter int RUN_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out,
  output logic              out_valid,
  output logic              stuff_flag,
  output logic              busy
);

  localparam int         CW  = $clog2(DATA_W + 1);
  localparam logic [3:0] LIM = 4'(RUN_LIMIT);

  typedef enum logic [1:0] {IDLE, SHIFT, STUFF} state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic [3:0]        run_cnt;
  logic              last_bit;

  logic          take;
  logic          do_stuff;
  logic          more;
  logic          nbit;
  logic [CW-1:0] nrem;
  logic [3:0]    nrun;

  // The registers describe the bit currently on out; this logic picks the next one.
  assign take     = in_valid && in_ready;
  assign do_stuff = (state == SHIFT) && (run_cnt == LIM);
  assign more     = (state != IDLE) && (bit_cnt != '0);
  assign nbit     = more ? shreg[DATA_W-1] : in_data[DATA_W-1];
  assign nrem     = more ? (bit_cnt - CW'(1)) : CW'(DATA_W - 1);
  assign nrun     = (nbit == last_bit && out_valid) ? (run_cnt + 4'd1) : 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      stuff_flag <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
      run_cnt    <= '0;
      last_bit   <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
    end else if (do_stuff) begin
      state      <= STUFF;
      out        <= ~last_bit;
      out_valid  <= 1'b1;
      stuff_flag <= 1'b1;
      busy       <= 1'b1;
      run_cnt    <= 4'd1;
      last_bit   <= ~last_bit;
      in_ready   <= (bit_cnt == '0);
    end else if (more || take) begin
      state      <= SHIFT;
      out        <= nbit;
      out_valid  <= 1'b1;
      stuff_flag <= 1'b0;
      busy       <= 1'b1;
      run_cnt    <= nrun;
      last_bit   <= nbit;
      bit_cnt    <= nrem;
      shreg      <= more ? (shreg << 1) : (in_data << 1);
      // Accept the next word only if this last bit will not force a trailing stuff bit.
      in_ready   <= (nrem == '0) && (nrun != LIM);
    end else begin
      state      <= IDLE;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      stuff_flag <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
      run_cnt    <= '0;
      last_bit   <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
    end
  end

endmodule

// File: tb/tb_run_limit_tx.sv
// tb/tb_run_limit_tx.sv - scoreboard bench for run_limit_tx
module tb_run_limit_tx;
  localparam int DATA_W    = 8;
  localparam int RUN_LIMIT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out;
  logic              out_valid;
  logic              stuff_flag;
  logic              busy;

  run_limit_tx #(.DATA_W(DATA_W), .RUN_LIMIT(RUN_LIMIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out(out), .out_valid(out_valid), .stuff_flag(stuff_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic b;
    logic s;
    int   c;
  } item_t;

  item_t expq[$];
  bit    hist[$];
  int    last_end = -10;
  int    hs_cyc = 0;
  int    tests = 0;
  int    failed = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Length of the identical-bit run at the end of the current stream.
  function automatic int trail_run();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  item_t it;
  int    run_len = 0;
  logic  prev_bit = 1'b0;
  logic  prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      while (expq.size() > 0 && expq[0].c < cyc) begin
        tests++;
        failed++;
        $display("FAIL missed_item cycle=%0d actual=absent required=item_for_cycle_%0d", cyc, expq[0].c);
        void'(expq.pop_front());
      end
      if (expq.size() > 0 && expq[0].c == cyc) begin
        it = expq.pop_front();
        chk("out_valid", int'(out_valid), 1);
        chk("out", int'(out), int'(it.b));
        chk("stuff_flag", int'(stuff_flag), int'(it.s));
        chk("busy", int'(busy), 1);
      end else if (out_valid) begin
        tests++;
        failed++;
        $display("FAIL unexpected_bit cycle=%0d actual=out_valid_1 required=out_valid_0", cyc);
      end else begin
        chk("busy_idle", int'(busy), 0);
      end
      if (out_valid) begin
        run_len = (prev_valid && out == prev_bit) ? run_len + 1 : 1;
        tests++;
        if (run_len > RUN_LIMIT) begin
          failed++;
          $display("FAIL run_limit cycle=%0d actual=%0d required_max=%0d", cyc, run_len, RUN_LIMIT);
        end
      end
      prev_valid = out_valid;
      prev_bit   = out;
    end
  end

  task automatic send(input logic [DATA_W-1:0] d);
    int  start;
    int  c;
    int  idx;
    int  exp_c;
    bit  ok;
    bit  b;
    start    = cyc;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 100; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      tests++;
      failed++;
      $display("FAIL ready_timeout cycle=%0d actual=in_ready_low required=in_ready_high", cyc);
    end else begin
      c      = cyc;
      hs_cyc = c;
      exp_c  = (start > last_end) ? start : last_end;
      chk("handshake_cycle", c, exp_c);
      if (c != last_end) hist.delete();
      idx = 0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
        b = d[i];
        hist.push_back(b);
        expq.push_back('{b: b, s: 1'b0, c: c + 1 + idx});
        idx++;
        if (trail_run() == RUN_LIMIT) begin
          hist.push_back(!b);
          expq.push_back('{b: !b, s: 1'b1, c: c + 1 + idx});
          idx++;
        end
      end
      last_end = c + idx;
    end
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_done(input int extra);
    in_valid = 1'b0;
    for (int k = 0; k < 100 && cyc <= last_end; k++) tick();
    repeat (extra) tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_out"}, int'(out), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_stuff_flag"}, int'(stuff_flag), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;

    send(8'hA5);
    wait_done(2);
    send(8'hFF);
    wait_done(2);
    send(8'h00);
    wait_done(2);
    send(8'h0F);
    send(8'hF0);
    wait_done(2);
    send(8'h07);
    wait_done(1);
    send(8'hE0);
    wait_done(2);

    // Abandon a word mid-flight, then confirm a clean restart.
    send(8'hFF);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && cyc < hs_cyc + 4; k++) tick();
    rst = 1'b1;
    while (expq.size() > 0 && expq[expq.size() - 1].c > cyc) void'(expq.pop_back());
    tick();
    check_idle_outputs("midreset");
    rst      = 1'b0;
    last_end = -10;
    hist.delete();
    send(8'hA5);
    wait_done(2);

    for (int w = 0; w < 40; w++) begin
      send(DATA_W'($urandom));
      idle($urandom_range(0, 12));
    end
    wait_done(2);

    for (int k = 0; k < 200 && expq.size() > 0; k++) tick();
    if (expq.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain cycle=%0d actual=%0d_pending required=0_pending", cyc, expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
